// File: rtl/send_tx_inf_pkg.sv
// Shared definitions for the serial word transmitter: FSM states, frame geometry
// and the bit-period clamp applied when a word is popped.
package send_tx_inf_pkg;

    localparam int DATA_BITS = 16;
    localparam int FRM_BITS  = 18;
    localparam int TPER_MIN  = 2;
    localparam int TPER_W    = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    function automatic logic [TPER_W-1:0] clamp_tper(input logic [TPER_W-1:0] period);
        return (period < TPER_W'(TPER_MIN)) ? TPER_W'(TPER_MIN) : period;
    endfunction

endpackage

// File: rtl/send_tx_inf_fifo.sv
// Synchronous word FIFO holding {frm,data}; extra pointer MSB tells full from empty.
module send_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 17
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push;
    logic         pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    // A full FIFO refuses the write even when the head is popped in the same cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Head word comes straight from the register array so it can be loaded in the pop cycle.
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is left unreset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/send_tx_inf.sv
// Serial word transmitter: buffers {frm,data} words and sends each as
// start bit, 16 data bits LSB first, stop bit, with an idle gap before new packets.
module send_tx_inf
    import send_tx_inf_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int GAP_BITS = 2
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [15:0]       tx_data,
    input  logic              tx_vld,
    input  logic              tx_frm,
    output logic              tx_rdy,
    input  logic [TPER_W-1:0] tbit_period,
    output logic              tx,
    output logic              tx_busy,
    output logic [AW:0]       fifo_level,
    output logic              tx_ovf
);

    tx_state_t         state;
    logic [TPER_W-1:0] tper;
    logic [TPER_W-1:0] timer;
    logic [3:0]        bit_cnt;
    logic [15:0]       shreg;
    logic              sent_any;
    logic [16:0]       head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              bit_end;

    send_fifo #(.DEPTH(DEPTH), .AW(AW), .W(17)) u_fifo (
        .clk_sys (clk_sys),
        .rst     (rst),
        .wr_en   (tx_vld),
        .wr_data ({tx_frm, tx_data}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign tx_rdy  = !full;
    assign tx_busy = (state != S_IDLE) || !empty;
    assign bit_end = (timer == tper - TPER_W'(1));
    assign pop     = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            tper     <= TPER_W'(TPER_MIN);
            timer    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sent_any <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            if (tx_vld && !tx_rdy) tx_ovf <= 1'b1;
            timer <= bit_end ? '0 : timer + TPER_W'(1);

            if (pop) begin
                // Period is sampled here only; a mid-frame change applies to the next word.
                shreg    <= head[15:0];
                tper     <= clamp_tper(tbit_period);
                sent_any <= 1'b1;
                timer    <= '0;
                bit_cnt  <= '0;
                if (head[16] && sent_any) begin
                    state <= S_GAP;
                    tx    <= 1'b1;
                end else begin
                    state <= S_START;
                    tx    <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        timer <= '0;
                        tx    <= 1'b1;
                    end
                    S_GAP: if (bit_end) begin
                        if (bit_cnt == 4'(GAP_BITS - 1)) begin
                            state   <= S_START;
                            tx      <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_START: if (bit_end) begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                    end
                    S_DATA: if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            state   <= S_STOP;
                            tx      <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_STOP: if (bit_end) begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
